// File: rtl/data_sram_like_resp.sv
// Responder for the data-side sram-like interface: word RAM plus an in-order queue
// that returns data_ok/rdata a fixed LAT cycles after each accepted request.
module data_sram_like_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        hold_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AgeW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [AgeW-1:0] LatC    = AgeW'(LAT);
  localparam logic [AgeW-1:0] LastAge = AgeW'(LAT - 1);

  typedef struct packed {
    logic            is_wr;
    logic [31:0]     data;
    logic [AgeW-1:0] age;
  } entry_t;

  logic [31:0]     mem_q [2**ADDR_W];
  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic              pop;
  entry_t            head;

  // Size and the unindexed address bits are informational only.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr};

  assign word_idx = data_sram_addr[ADDR_W+1:2];
  assign head     = q_q[rd_ptr_q];

  always_comb begin
    data_sram_addr_ok = (count_q < DepthC) & ~hold_i;
    data_sram_data_ok = (count_q != '0) & (head.age == LastAge);
    data_sram_rdata   = (data_sram_data_ok & ~head.is_wr) ? head.data : 32'h0;
  end

  assign accept = data_sram_req & data_sram_addr_ok;
  assign pop    = data_sram_data_ok;

  always_comb begin
    q_d      = q_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Every slot ages; free slots are overwritten with age 0 on push anyway.
    for (int i = 0; i < DEPTH; i++) begin
      if (q_q[i].age != LatC) begin
        q_d[i].age = q_q[i].age + AgeW'(1);
      end
    end

    if (accept) begin
      q_d[wr_ptr_q].is_wr = data_sram_wr;
      q_d[wr_ptr_q].data  = data_sram_wr ? 32'h0 : mem_q[word_idx];
      q_d[wr_ptr_q].age   = '0;
      wr_ptr_d            = wr_ptr_q + PtrW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
    end
  end

  // RAM is never cleared; gating with resetn keeps a request held during reset out of it.
  always_ff @(posedge clk) begin
    if (resetn && accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!resetn) count_q <= DepthC);
  assert property (@(posedge clk) disable iff (!resetn) !(accept && count_q == DepthC));

endmodule

// File: tb/tb_data_sram_like_resp.sv
// Directed bench: a LAT=2 responder checked through a due-cycle queue, plus a LAT=4
// responder that is scripted cycle by cycle to exercise the full queue and mid-flight reset.
module tb_data_sram_like_resp;

  localparam int unsigned Lat = 2;

  logic        clk;
  logic        resetn;
  logic        req, req2, wr, hold;
  logic [3:0]  wstrb;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, addr_ok2, data_ok2;
  logic [31:0] rdata, rdata2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  data_sram_like_resp u_dut (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_wstrb   (wstrb),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .hold_i            (hold)
  );

  data_sram_like_resp #(
    .ADDR_W (10),
    .DEPTH  (4),
    .LAT    (4)
  ) u_deep (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req2),
    .data_sram_wr      (wr),
    .data_sram_wstrb   (wstrb),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok2),
    .data_sram_data_ok (data_ok2),
    .data_sram_rdata   (rdata2),
    .hold_i            (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each response of the LAT=2 instance is due in one exact cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("data_ok", data_ok, 1);
        check("rdata", rdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check("data_ok_idle", data_ok, 0);
        check("rdata_idle", rdata, 0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, output int waited);
    logic ok;
    exp_t e;
    waited = 0;
    ok     = 1'b0;
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d; size = 2'd2;
    while (!ok && waited < 20) begin
      @(negedge clk);
      ok = addr_ok;
      tick();
      waited++;
    end
    req = 1'b0;
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.due  = cyc + Lat - 1;
      e.data = exp_rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic deep_write(input logic [31:0] a, input logic [31:0] d);
    req2 = 1'b1; wr = 1'b1; wstrb = 4'hf; addr = a; wdata = d;
    @(negedge clk);
    check("deep_wr_addr_ok", addr_ok2, 1);
    tick();
    req2 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      tick();
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  logic        ok_tab  [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
  logic        dok_tab [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
  logic [31:0] rd_tab  [12] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003,
                                32'h0, 32'hA0A0_0004, 32'hA0A0_0005, 32'h0};

  initial begin
    int  n;
    int  j;
    logic take;

    resetn = 1'b0; req = 1'b0; req2 = 1'b0; hold = 1'b0;
    wr = 1'b0; wstrb = 4'h0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) tick();
    resetn = 1'b1;
    mon_en = 1'b1;

    @(negedge clk);
    check("rst_addr_ok", addr_ok, 1);
    check("rst_data_ok", data_ok, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr_ok2", addr_ok2, 1);
    check("rst_data_ok2", data_ok2, 0);
    tick();

    // Full-word write then read; later partial-lane updates.
    do_req(1'b1, 4'hf, 32'h10, 32'hDEAD_BEEF, 32'h0, n);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, n);
    do_req(1'b1, 4'h4, 32'h10, 32'h00AA_0000, 32'h0, n);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_BEEF, n);
    do_req(1'b1, 4'h3, 32'h10, 32'h0000_1234, 32'h0, n);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_1234, n);
    do_req(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h0, n);
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_1234, n);

    // 0x1000 aliases word 0.
    do_req(1'b1, 4'hf, 32'h1000, 32'h1111_1111, 32'h0, n);
    do_req(1'b0, 4'h0, 32'h0, 32'h0, 32'h1111_1111, n);
    drain();

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) do_req(1'b0, 4'h0, 32'h0, 32'h0, 32'h1111_1111, n);
      else            do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_1234, n);
      check($sformatf("stream_wait_%0d", i), n, 1);
    end
    drain();

    // Hold while a read is in flight: it still returns on schedule.
    do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAA_1234, n);
    hold = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_addr_ok_%0d", i), addr_ok, 0);
      tick();
    end
    req = 1'b0; hold = 1'b0;
    @(negedge clk);
    check("hold_release_addr_ok", addr_ok, 1);
    tick();
    drain();

    // LAT=4 instance: preload, then fill the queue.
    for (int i = 0; i < 6; i++) begin
      deep_write(32'h40 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
    end
    j = 0;
    for (int t = 0; t < 12; t++) begin
      req2 = (j < 6); wr = 1'b0; addr = 32'h40 + 32'(4 * j);
      @(negedge clk);
      check($sformatf("full_addr_ok_t%0d", t), addr_ok2, 32'(ok_tab[t]));
      check($sformatf("full_data_ok_t%0d", t), data_ok2, 32'(dok_tab[t]));
      check($sformatf("full_rdata_t%0d", t), rdata2, rd_tab[t]);
      take = req2 & addr_ok2;
      tick();
      if (take) j++;
    end
    req2 = 1'b0;
    repeat (2) tick();

    // Three reads in flight, then reset before the first is due.
    for (int t = 0; t < 3; t++) begin
      req2 = 1'b1; wr = 1'b0; addr = 32'h40 + 32'(4 * t);
      @(negedge clk);
      check($sformatf("pre_rst_addr_ok_%0d", t), addr_ok2, 1);
      tick();
    end
    req2 = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("pre_rst_data_ok", data_ok2, 0);
    tick();
    resetn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check($sformatf("post_rst_data_ok_%0d", t), data_ok2, 0);
      check($sformatf("post_rst_addr_ok_%0d", t), addr_ok2, 1);
      tick();
    end

    // Four accepts in a row prove the count restarted at zero; RAM kept its words.
    for (int t = 0; t < 9; t++) begin
      req2 = (t < 4); wr = 1'b0; addr = 32'h40 + 32'(4 * t);
      @(negedge clk);
      if (t < 4) check($sformatf("post_rst_accept_%0d", t), addr_ok2, 1);
      check($sformatf("post_rst_rd_ok_t%0d", t), data_ok2, (t >= 4 && t < 8) ? 1 : 0);
      check($sformatf("post_rst_rd_t%0d", t), rdata2,
            (t >= 4 && t < 8) ? 32'hA0A0_0000 + 32'(t - 4) : 32'h0);
      tick();
    end
    req2 = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
